// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_arbiter (with helper module alu)
// Description : Two-requester front end for a single shared ALU. A winner is
//               granted in IDLE, its operands are captured, the ALU result is
//               registered in EXEC and held in RESP until the owner accepts.
// Config      : ALU_ARB_RR_EN defined   -> round-robin arbitration
//               ALU_ARB_RR_EN undefined -> fixed priority, req0 wins
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  sel0,
  input  logic [2:0]  sel1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  input  logic        rsp_ready0,
  input  logic        rsp_ready1,
  output logic [31:0] rsp_result,
  output logic        rsp_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        owner_q, owner_d;      // 0: requester 0 owns the ALU, 1: requester 1
  logic        rsp_valid0_q, rsp_valid0_d;
  logic        rsp_valid1_q, rsp_valid1_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  // Low while in reset and for the first edge after release, so a grant can
  // never be shown combinationally while reset is still asserted.
  logic        run_q, run_d;

  logic        win1;                  // requester 1 wins the current arbitration
  logic        take;                  // a grant happens this cycle
  logic        owner_ready;
  logic [31:0] alu_result;
  logic        alu_zero;

`ifdef ALU_ARB_RR_EN
  logic        prio_q, prio_d;        // 1: requester 1 has priority on a tie

  // Round-robin winner: a tie goes to whichever side the pointer favours
  always_comb begin
    win1 = req1 && (!req0 || prio_q);
  end
`else
  // Fixed priority winner: requester 0 always wins a tie
  always_comb begin
    win1 = req1 && !req0;
  end
`endif

  // Grant pulse is decoded in the IDLE cycle so operands are captured the
  // same cycle the requester sees its grant
  always_comb begin
    take  = (state_q == IDLE) && (req0 || req1) && run_q;
  end

  assign gnt0       = take && !win1;
  assign gnt1       = take && win1;
  assign rsp_valid0 = rsp_valid0_q;
  assign rsp_valid1 = rsp_valid1_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

  // Only the current owner's ready can release the response
  always_comb begin
    owner_ready = owner_q ? rsp_ready1 : rsp_ready0;
  end

  // The shared ALU only ever sees the captured operands
  alu u_alu (
    .alu_sel  (sel_q),
    .Operand1 (a_q),
    .Operand2 (b_q),
    .Result   (alu_result),
    .flagZ    (alu_zero)
  );

  // Next-state and next-output computation for the IDLE/EXEC/RESP sequence
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    a_d          = a_q;
    b_d          = b_q;
    owner_d      = owner_q;
    rsp_valid0_d = rsp_valid0_q;
    rsp_valid1_d = rsp_valid1_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    run_d        = 1'b1;
`ifdef ALU_ARB_RR_EN
    prio_d       = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (take) begin
          owner_d = win1;
          sel_d   = win1 ? sel1 : sel0;
          a_d     = win1 ? a1   : a0;
          b_d     = win1 ? b1   : b0;
          state_d = EXEC;
`ifdef ALU_ARB_RR_EN
          // Hand priority to the requester that just lost out
          prio_d  = !win1;
`endif
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_valid0_d = !owner_q;
        rsp_valid1_d = owner_q;
        state_d      = RESP;
      end
      RESP: begin
        if (owner_ready) begin
          rsp_valid0_d = 1'b0;
          rsp_valid1_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        rsp_valid0_d = 1'b0;
        rsp_valid1_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 3'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      owner_q      <= 1'b0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
      run_q        <= 1'b0;
`ifdef ALU_ARB_RR_EN
      prio_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      a_q          <= a_d;
      b_q          <= b_d;
      owner_q      <= owner_d;
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      run_q        <= run_d;
`ifdef ALU_ARB_RR_EN
      prio_q       <= prio_d;
`endif
    end
  end

endmodule

// ============================================================================
// Module      : alu
// Description : Combinational 32-bit ALU. Undefined codes give a zero result
//               with the zero flag cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module alu (
  input  logic [2:0]  alu_sel,
  input  logic [31:0] Operand1,
  input  logic [31:0] Operand2,
  output logic [31:0] Result,
  output logic        flagZ
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_EQU = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic defined;

  // Operation decode; the zero flag is only meaningful for defined codes
  always_comb begin
    Result  = 32'd0;
    defined = 1'b1;
    case (alu_sel)
      OP_AND:  Result = Operand1 & Operand2;
      OP_OR:   Result = Operand1 | Operand2;
      OP_ADD:  Result = Operand1 + Operand2;
      OP_SUB:  Result = Operand1 - Operand2;
      OP_SLT:  Result = {31'd0, (Operand1 < Operand2)};
      OP_EQU:  Result = {31'd0, (Operand1 == Operand2)};
      default: defined = 1'b0;
    endcase
    flagZ = defined && (Result == 32'd0);
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Scoreboard bench for alu_arbiter. A monitor pushes the expected
//               response at every grant and pops it at the handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [2:0]  sel0, sel1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, rsp_valid0, rsp_valid1;
  logic        rsp_ready0, rsp_ready1;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        owner;
    logic [31:0] res;
    logic        z;
    int          gcyc;
  } exp_t;

  exp_t sb[$];
  int   cyc        = 0;
  int   resp_count = 0;
  logic m_prio     = 1'b0;
  logic prev_valid = 1'b0;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .sel0       (sel0),
    .sel1       (sel1),
    .a0         (a0),
    .b0         (b0),
    .a1         (a1),
    .b1         (b1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rsp_valid0 (rsp_valid0),
    .rsp_valid1 (rsp_valid1),
    .rsp_ready0 (rsp_ready0),
    .rsp_ready1 (rsp_ready1),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference ALU: returns {zero, result}
  function automatic logic [32:0] alu_ref(input logic [2:0] s, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [31:0] r;
    logic        def;
    r   = 32'd0;
    def = 1'b1;
    case (s)
      3'b010:  r = x + y;
      3'b110:  r = x - y;
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b111:  r = (x < y) ? 32'd1 : 32'd0;
      3'b101:  r = (x == y) ? 32'd1 : 32'd0;
      default: def = 1'b0;
    endcase
    return {def && (r == 32'd0), r};
  endfunction

  // Monitor: predicts the winner, queues expected responses, checks outputs
  always @(negedge clk) begin : mon
    logic w;
    exp_t e;
    cyc++;
    if (rst) begin
      sb.delete();
      m_prio     = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
`ifdef ALU_ARB_RR_EN
        if (req0 && req1) w = m_prio;
        else              w = req1 && !req0;
`else
        w = req1 && !req0;
`endif
        check("gnt_winner", {gnt1, gnt0}, (req0 || req1) ? (w ? 2'b10 : 2'b01) : 2'b00);
        e.owner = w;
        {e.z, e.res} = w ? alu_ref(sel1, a1, b1) : alu_ref(sel0, a0, b0);
        e.gcyc  = cyc;
        sb.push_back(e);
        m_prio  = !w;
      end
      if (rsp_valid0 || rsp_valid1) begin
        if (sb.size() == 0) begin
          check("spurious_valid", {rsp_valid1, rsp_valid0}, 2'b00);
        end else begin
          e = sb[0];
          check("valid_owner", {rsp_valid1, rsp_valid0}, e.owner ? 2'b10 : 2'b01);
          if (!prev_valid) begin
            check("latency", cyc - e.gcyc, 2);
            check("result", rsp_result, e.res);
            check("zero", rsp_zero, e.z);
          end else begin
            check("hold_result", {rsp_zero, rsp_result}, {e.z, e.res});
          end
          if (e.owner ? rsp_ready1 : rsp_ready0) begin
            sb.delete(0);
            resp_count++;
          end
        end
      end
      prev_valid = rsp_valid0 || rsp_valid1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the grant of the given requester; returns at its negedge
  task automatic wait_gnt(input bit who);
    int k;
    k = 0;
    @(negedge clk);
    while (!(who ? gnt1 : gnt0) && k < 12) begin
      @(negedge clk);
      k++;
    end
    check("gnt_timeout", (k < 12), 1);
  endtask

  task automatic wait_resp(input int n);
    int k;
    k = 0;
    while (resp_count < n && k < 30) begin
      tick();
      k++;
    end
    check("resp_timeout", (resp_count >= n), 1);
  endtask

  task automatic single(input bit who, input logic [2:0] s, input logic [31:0] x,
                        input logic [31:0] y);
    int n;
    n = resp_count + 1;
    if (who) begin req1 = 1'b1; sel1 = s; a1 = x; b1 = y; end
    else     begin req0 = 1'b1; sel0 = s; a0 = x; b0 = y; end
    wait_gnt(who);
    tick();
    if (who) req1 = 1'b0; else req0 = 1'b0;
    wait_resp(n);
  endtask

  initial begin : stim
    int n;
    int gl[$];
    int gc[$];
    int k;
    int lc;

    rst = 1'b1; req0 = 1'b1; req1 = 1'b0;
    sel0 = 3'd0; sel1 = 3'd0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_gnt", {gnt1, gnt0}, 2'b00);
    check("rst_valid", {rsp_valid1, rsp_valid0}, 2'b00);
    check("rst_result", {rsp_zero, rsp_result}, 33'd0);
    req0 = 1'b0;
    rst  = 1'b0;
    tick();
    tick();

    // Basic operations, including boundary codes
    single(0, 3'b010, 32'd5, 32'd7);
    check("add_result", {rsp_zero, rsp_result}, {1'b0, 32'd12});
    single(1, 3'b110, 32'h1234, 32'h1234);
    check("sub_result", {rsp_zero, rsp_result}, {1'b1, 32'd0});
    single(0, 3'b111, 32'd1, 32'hFFFF_FFFF);
    check("slt_result", {rsp_zero, rsp_result}, {1'b0, 32'd1});
    single(0, 3'b011, 32'd5, 32'd7);
    check("undef011_result", {rsp_zero, rsp_result}, {1'b0, 32'd0});
    single(1, 3'b100, 32'd3, 32'd3);
    check("undef100_result", {rsp_zero, rsp_result}, {1'b0, 32'd0});
    single(0, 3'b000, 32'h0000_F0F0, 32'h0000_FF00);
    single(1, 3'b001, 32'h1200_0000, 32'h0000_0034);
    single(0, 3'b101, 32'd9, 32'd9);
    single(0, 3'b111, 32'hFFFF_FFFF, 32'd1);
    single(1, 3'b101, 32'd9, 32'd8);

    // Both requesters held for four operations, ready tied high
    n = resp_count + 4;
    req0 = 1'b1; sel0 = 3'b010; a0 = 32'd100; b0 = 32'd1;
    req1 = 1'b1; sel1 = 3'b110; a1 = 32'd100; b1 = 32'd1;
    k  = 0;
    lc = 0;
    while (gl.size() < 4 && k < 40) begin
      @(negedge clk);
      lc++;
      k++;
      if (gnt0 || gnt1) begin
        gl.push_back(gnt1 ? 1 : 0);
        gc.push_back(lc);
      end
    end
    tick();
    req0 = 1'b0; req1 = 1'b0;
    check("tie_grant_count", gl.size(), 4);
    for (int i = 0; i < gl.size(); i++) begin
`ifdef ALU_ARB_RR_EN
      check("tie_grant_order", gl[i], i % 2);
`else
      check("tie_grant_order", gl[i], 0);
`endif
      if (i > 0) check("issue_interval", gc[i] - gc[i-1], 3);
    end
    wait_resp(n);

    // Owner stalls for five RESP cycles while requester 1 waits
    n = resp_count + 1;
    rsp_ready0 = 1'b0;
    req0 = 1'b1; sel0 = 3'b001; a0 = 32'h0000_00A5; b0 = 32'h0000_5A00;
    wait_gnt(0);
    tick();
    req0 = 1'b0;
    req1 = 1'b1; sel1 = 3'b010; a1 = 32'd100; b1 = 32'd23;
    @(negedge clk);
    check("no_gnt1_exec", gnt1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid0", {rsp_valid1, rsp_valid0}, 2'b01);
      check("stall_no_gnt1", gnt1, 0);
    end
    tick();
    rsp_ready0 = 1'b1;
    @(negedge clk);
    check("release_no_gnt1", {gnt1, rsp_valid0}, 2'b01);
    @(negedge clk);
    check("gnt1_after_release", gnt1, 1);
    tick();
    req1 = 1'b0;
    wait_resp(n + 1);
    check("stall_req1_result", rsp_result, 32'd123);

    // Reset pulsed in EXEC aborts the operation
    req0 = 1'b1; sel0 = 3'b010; a0 = 32'h10; b0 = 32'h20;
    wait_gnt(0);
    tick();
    req0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {rsp_valid1, rsp_valid0}, 2'b00);
    check("arst_result", {rsp_zero, rsp_result}, 33'd0);
    req0 = 1'b1;
    #1;
    check("arst_gnt_gated", {gnt1, gnt0}, 2'b00);
    req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_valid_after_rst", {rsp_valid1, rsp_valid0}, 2'b00);
    end
    tick();

    // Recovery after reset
    single(0, 3'b010, 32'd5, 32'd7);
    check("post_rst_add", {rsp_zero, rsp_result}, {1'b0, 32'd12});

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
